// File: rtl/sched_flag_table.sv
// Per-flow {flag, ts} store with a two-stage read-modify-write command path
// and a round-robin scan that presents set flows to the downstream scheduler.

module sched_flag_entry #(
  parameter int TS_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            upd,
  input  logic [1:0]      op,
  input  logic [TS_W-1:0] cmd_ts,
  output logic            flag,
  output logic [TS_W-1:0] ts
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
      ts   <= '0;
    end else if (upd) begin
      case (op)
        2'd1: begin
          flag <= 1'b1;
          ts   <= ts + TS_W'(1);
        end
        // A clear older than the stored timestamp lost a race with a SET.
        2'd2: if (!(cmd_ts < ts)) flag <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

module sched_flag_table #(
  parameter int NUM_FLOWS = 16,
  parameter int FLOWID_W  = $clog2(NUM_FLOWS),
  parameter int TS_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_val,
  input  logic [FLOWID_W-1:0] cmd_flowid,
  input  logic [1:0]          cmd_op,
  input  logic [TS_W-1:0]     cmd_ts,
  output logic                cmd_rdy,
  output logic                sched_val,
  output logic [FLOWID_W-1:0] sched_flowid,
  output logic [TS_W-1:0]     sched_ts,
  input  logic                sched_rdy
);
  typedef enum logic {SCAN, PRESENT} state_t;

  state_t                           state;
  logic [FLOWID_W-1:0]              scan_ptr;
  logic                             s1_val;
  logic [FLOWID_W-1:0]              s1_flowid;
  logic [1:0]                       s1_op;
  logic [TS_W-1:0]                  s1_ts;
  logic [NUM_FLOWS-1:0]             flag_q;
  logic [NUM_FLOWS-1:0][TS_W-1:0]   ts_q;

  // S0: register the accepted command; the path never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rdy   <= 1'b0;
      s1_val    <= 1'b0;
      s1_flowid <= '0;
      s1_op     <= 2'd0;
      s1_ts     <= '0;
    end else begin
      cmd_rdy <= 1'b1;
      s1_val  <= cmd_val && cmd_rdy;
      if (cmd_val && cmd_rdy) begin
        s1_flowid <= cmd_flowid;
        s1_op     <= cmd_op;
        s1_ts     <= cmd_ts;
      end
    end
  end

  // S1: each entry applies the update when addressed; write lands at the edge.
  for (genvar e = 0; e < NUM_FLOWS; e++) begin : g_ent
    sched_flag_entry #(.TS_W(TS_W)) u_ent (
      .clk    (clk),
      .rst_n  (rst_n),
      .upd    (s1_val && (s1_flowid == FLOWID_W'(e))),
      .op     (s1_op),
      .cmd_ts (s1_ts),
      .flag   (flag_q[e]),
      .ts     (ts_q[e])
    );
  end

  // Scan reads registered table contents, so a same-cycle write is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= SCAN;
      scan_ptr     <= '0;
      sched_val    <= 1'b0;
      sched_flowid <= '0;
      sched_ts     <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (flag_q[scan_ptr]) begin
            sched_flowid <= scan_ptr;
            sched_ts     <= ts_q[scan_ptr];
            sched_val    <= 1'b1;
            state        <= PRESENT;
          end else begin
            scan_ptr <= scan_ptr + FLOWID_W'(1);
          end
        end
        PRESENT: begin
          if (sched_rdy) begin
            sched_val <= 1'b0;
            scan_ptr  <= sched_flowid + FLOWID_W'(1);
            state     <= SCAN;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule

// File: tb/tb_sched_flag_table.sv
// Directed bench for sched_flag_table: reset, set/clear, stale clear, ts wrap,
// round-robin order and backpressure with updates to the presented flow.

module tb_sched_flag_table;
  logic       clk;
  logic       rst_n;
  logic       cmd_val;
  logic [3:0] cmd_flowid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_ts;
  logic       cmd_rdy;
  logic       sched_val;
  logic [3:0] sched_flowid;
  logic [7:0] sched_ts;
  logic       sched_rdy;

  int checks = 0;
  int errors = 0;

  sched_flag_table #(.NUM_FLOWS(16), .TS_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_val      (cmd_val),
    .cmd_flowid   (cmd_flowid),
    .cmd_op       (cmd_op),
    .cmd_ts       (cmd_ts),
    .cmd_rdy      (cmd_rdy),
    .sched_val    (sched_val),
    .sched_flowid (sched_flowid),
    .sched_ts     (sched_ts),
    .sched_rdy    (sched_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input int f, input int op, input int ts);
    logic [31:0] fv, ov, tv;
    fv = f; ov = op; tv = ts;
    cmd_val    = 1'b1;
    cmd_flowid = fv[3:0];
    cmd_op     = ov[1:0];
    cmd_ts     = tv[7:0];
    step();
    cmd_val = 1'b0;
  endtask

  task automatic wait_present(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sched_val) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  function automatic int rr_next(input int f);
    if (f == 2) return 7;
    if (f == 7) return 15;
    return 2;
  endfunction

  initial begin
    int seen;
    int pres[6];
    int np;
    int f, t;

    rst_n = 1'b0; cmd_val = 1'b0; cmd_flowid = '0; cmd_op = '0; cmd_ts = '0; sched_rdy = 1'b0;

    // Reset state
    #12;
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_sched_val", 32'(sched_val), 32'd0);
    check("rst_sched_flowid", 32'(sched_flowid), 32'd0);
    check("rst_sched_ts", 32'(sched_ts), 32'd0);
    rst_n = 1'b1;
    step();
    check("cmd_rdy_after_rst", 32'(cmd_rdy), 32'd1);

    // Single SET / CLEAR
    do_cmd(5, 1, 0);
    wait_present("set5_present", 40);
    check("set5_flowid", 32'(sched_flowid), 32'd5);
    check("set5_ts", 32'(sched_ts), 32'd1);
    step(); step(); step();
    check("set5_hold_val", 32'(sched_val), 32'd1);
    check("set5_hold_flowid", 32'(sched_flowid), 32'd5);
    sched_rdy = 1'b1;
    step();
    check("set5_handshake_drop", 32'(sched_val), 32'd0);
    sched_rdy = 1'b0;
    do_cmd(5, 2, 1);
    step();
    check("clr5_flag", 32'(dut.flag_q[5]), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (sched_val) seen++;
      step();
    end
    check("clr5_no_present", 32'(seen), 32'd0);

    // Stale CLEAR
    do_cmd(3, 1, 0);
    do_cmd(3, 1, 0);
    step();
    check("set3x2_ts", 32'(dut.ts_q[3]), 32'd2);
    check("set3x2_flag", 32'(dut.flag_q[3]), 32'd1);
    do_cmd(3, 2, 1);
    step();
    check("stale_clr3_flag", 32'(dut.flag_q[3]), 32'd1);
    do_cmd(3, 2, 2);
    step();
    check("clr3_flag", 32'(dut.flag_q[3]), 32'd0);
    check("clr3_ts_kept", 32'(dut.ts_q[3]), 32'd2);
    sched_rdy = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("drain3_idle", 32'(sched_val), 32'd0);

    // Timestamp wrap on flow 0
    for (int i = 0; i < 255; i++) do_cmd(0, 1, 0);
    step();
    check("wrap_ts255", 32'(dut.ts_q[0]), 32'd255);
    do_cmd(0, 1, 0);
    step();
    check("wrap_ts0", 32'(dut.ts_q[0]), 32'd0);
    check("wrap_flag", 32'(dut.flag_q[0]), 32'd1);
    do_cmd(0, 2, 0);
    step();
    check("wrap_clr_flag", 32'(dut.flag_q[0]), 32'd0);
    for (int i = 0; i < 20; i++) step();
    check("drain0_idle", 32'(sched_val), 32'd0);

    // Round-robin over 2, 7, 15 from a fresh reset
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    do_cmd(2, 1, 0);
    do_cmd(7, 1, 0);
    do_cmd(15, 1, 0);
    np = 0;
    for (int i = 0; i < 300 && np < 6; i++) begin
      if (sched_val) begin
        pres[np] = 32'(sched_flowid);
        check($sformatf("rr_ts_%0d", np), 32'(sched_ts), 32'd1);
        np++;
      end
      step();
    end
    check("rr_count", 32'(np), 32'd6);
    check("rr_first_member", 32'((pres[0] == 2) || (pres[0] == 7) || (pres[0] == 15)), 32'd1);
    for (int i = 1; i < 6; i++)
      check($sformatf("rr_order_%0d", i), 32'(pres[i]), 32'(rr_next(pres[i-1])));

    // Backpressure: repeated SETs to the held flow
    sched_rdy = 1'b0;
    step();
    wait_present("bp_present", 40);
    f = 32'(sched_flowid);
    t = 32'(sched_ts);
    for (int i = 1; i <= 10; i++) begin
      do_cmd(f, 1, 0);
      check($sformatf("bp_val_%0d", i), 32'(sched_val), 32'd1);
      check($sformatf("bp_flowid_%0d", i), 32'(sched_flowid), 32'(f));
      check($sformatf("bp_ts_%0d", i), 32'(sched_ts), 32'(t));
      check($sformatf("bp_cmd_rdy_%0d", i), 32'(cmd_rdy), 32'd1);
      check($sformatf("bp_tbl_ts_%0d", i), 32'(dut.ts_q[f]), 32'((t + i - 1) % 256));
    end
    step();
    check("bp_tbl_ts_final", 32'(dut.ts_q[f]), 32'((t + 10) % 256));
    sched_rdy = 1'b1;
    step();
    check("bp_handshake_drop", 32'(sched_val), 32'd0);
    sched_rdy = 1'b0;

    // Reset mid-presentation
    wait_present("rst_mid_present", 40);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_sched_val", 32'(sched_val), 32'd0);
    check("rst_mid_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_mid_flowid", 32'(sched_flowid), 32'd0);
    check("rst_mid_ts", 32'(sched_ts), 32'd0);
    check("rst_mid_table", 32'(dut.flag_q), 32'd0);
    check("rst_mid_ptr", 32'(dut.scan_ptr), 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    check("rst_first_scan_ptr", 32'(dut.scan_ptr), 32'd1);
    check("rst_after_val", 32'(sched_val), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
